// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// It uses 16 lines of 256 bits each and a single-request line interface to off-chip memory.
module dcache_ctrl #(
    parameter int NUM_LINES = 16,
    parameter int LINE_W    = 256,
    parameter int ADDR_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_read_i,
    input  logic              cpu_write_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int WORDS  = LINE_W / 32;
    localparam int WSEL_W = OFF_W - 2;
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [1:0] {IDLE, MISS, WBACK, REFILL} state_t;

    state_t                     state;
    logic [NUM_LINES-1:0]       valid_q;
    logic [NUM_LINES-1:0]       dirty_q;
    logic [TAG_W-1:0]           tag_q  [NUM_LINES];
    logic [WORDS-1:0][31:0]     data_q [NUM_LINES];
    logic [ADDR_W-1:0]          miss_addr;

    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [WSEL_W-1:0] word;
    logic [TAG_W-1:0]  m_tag;
    logic [IDX_W-1:0]  m_idx;
    logic              req;
    logic              hit;
    logic              idle;

    assign tag   = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign idx   = cpu_addr_i[OFF_W +: IDX_W];
    assign word  = cpu_addr_i[2 +: WSEL_W];
    assign m_tag = miss_addr[ADDR_W-1 -: TAG_W];
    assign m_idx = miss_addr[OFF_W +: IDX_W];
    assign req   = cpu_read_i | cpu_write_i;
    assign hit   = valid_q[idx] && (tag_q[idx] == tag);
    assign idle  = (state == IDLE);

    assign cpu_stall_o = req && !(idle && hit);

    always_comb begin
        cpu_rdata_o = '0;
        if (cpu_read_i && hit && idle)
            cpu_rdata_o = data_q[idx][word];
    end

    // The miss address is captured on leaving IDLE, so a line transaction stays
    // coherent even if the CPU request drops before it finishes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            miss_addr    <= '0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !hit) begin
                        state     <= MISS;
                        miss_addr <= cpu_addr_i;
                    end else if (cpu_write_i && hit) begin
                        dirty_q[idx] <= 1'b1;
                    end
                end
                MISS: begin
                    mem_enable_o <= 1'b1;
                    if (valid_q[m_idx] && dirty_q[m_idx]) begin
                        state       <= WBACK;
                        mem_write_o <= 1'b1;
                        mem_addr_o  <= {tag_q[m_idx], m_idx, {OFF_W{1'b0}}};
                        mem_wdata_o <= data_q[m_idx];
                    end else begin
                        state       <= REFILL;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    end
                end
                WBACK: begin
                    if (mem_ack_i) begin
                        dirty_q[m_idx] <= 1'b0;
                        mem_enable_o   <= 1'b0;
                        state          <= MISS;
                    end
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        valid_q[m_idx] <= 1'b1;
                        dirty_q[m_idx] <= 1'b0;
                        mem_enable_o   <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (state == REFILL && mem_ack_i) begin
            data_q[m_idx] <= mem_rdata_i;
            tag_q[m_idx]  <= m_tag;
        end else if (idle && cpu_write_i && hit) begin
            data_q[idx][word] <= cpu_wdata_i;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: it runs hits and clean and dirty misses, a reset during a refill,
// and a spurious memory ack, with a small memory responder.
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_read, cpu_write;
    logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
    logic         cpu_stall;
    logic         mem_enable, mem_write, mem_ack;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0]  log_addr  [4];
    logic         log_wr    [4];
    logic [255:0] log_wdata [4];
    int           n_req;

    dcache_ctrl #(.NUM_LINES(16), .LINE_W(256), .ADDR_W(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_read_i(cpu_read), .cpu_write_i(cpu_write),
        .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
        .mem_enable_o(mem_enable), .mem_write_o(mem_write),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] w0, input logic [31:0] w2);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'h0101_0101 * i;
        l[31:0]  = w0;
        l[95:64] = w2;
        return l;
    endfunction

    // Drives one access from a negedge, answers memory requests after lat_w/lat_r
    // enable cycles, and returns the number of stalled cycles.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input int lat_w, input int lat_r,
                          input logic [255:0] line, output int stalls,
                          output logic [31:0] rd_seen);
        int  en_cnt = 0;
        bit  done   = 0;
        stalls  = 0;
        rd_seen = '0;
        n_req   = 0;
        cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = wd;
        mem_rdata = line;
        #1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            mem_ack = 1'b0;
            if (!cpu_stall) begin
                rd_seen = cpu_rdata;
                done    = 1;
                break;
            end
            stalls++;
            if (mem_enable) begin
                if (en_cnt == 0 && n_req < 4) begin
                    log_addr[n_req]  = mem_addr;
                    log_wr[n_req]    = mem_write;
                    log_wdata[n_req] = mem_wdata;
                    n_req++;
                end
                en_cnt++;
                mem_ack = (en_cnt == (mem_write ? lat_w : lat_r));
            end else begin
                en_cnt = 0;
            end
            @(negedge clk); #1;
        end
        if (!done) check("access_timeout", 1, 0);
        @(negedge clk);
        cpu_read = 1'b0; cpu_write = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st;
        logic [31:0] rv;
        bit          seen;
        rst = 1'b1;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall_noreq", cpu_stall, 0);
        check("rst_mem_en", mem_enable, 0);
        check("rst_mem_wr", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        cpu_read = 1'b1; cpu_addr = 32'h40;
        #1;
        check("rst_stall_req", cpu_stall, 1);
        check("rst_rdata", cpu_rdata, 0);
        cpu_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: a clean miss on an empty cache
        access(1, 0, 32'h40, 0, 1, 2, mk_line(32'hDEADBEEF, 32'hCAFEF00D), st, rv);
        check("t1_stalls", st, 4);
        check("t1_rdata", rv, 32'hDEADBEEF);
        check("t1_nreq", n_req, 1);
        check("t1_req_addr", log_addr[0], 32'h40);
        check("t1_req_wr", log_wr[0], 0);
        access(1, 0, 32'h48, 0, 1, 1, '0, st, rv);
        check("t1_w2_stalls", st, 0);
        check("t1_w2_rdata", rv, 32'hCAFEF00D);

        // Test 2: a store hit, then a load hit
        access(0, 1, 32'h44, 32'h12345678, 1, 1, '0, st, rv);
        check("t2_st_stalls", st, 0);
        access(1, 0, 32'h44, 0, 1, 1, '0, st, rv);
        check("t2_ld_stalls", st, 0);
        check("t2_ld_rdata", rv, 32'h12345678);

        // Test 3: a dirty conflict miss on index 2
        access(1, 0, 32'h240, 0, 3, 1, mk_line(32'hA0A00240, 32'h0), st, rv);
        check("t3_stalls", st, 3 + 3 + 1);
        check("t3_nreq", n_req, 2);
        check("t3_wb_addr", log_addr[0], 32'h40);
        check("t3_wb_wr", log_wr[0], 1);
        check("t3_wb_word1", log_wdata[0][63:32], 32'h12345678);
        check("t3_wb_word0", log_wdata[0][31:0], 32'hDEADBEEF);
        check("t3_rf_addr", log_addr[1], 32'h240);
        check("t3_rf_wr", log_wr[1], 0);
        check("t3_rdata", rv, 32'hA0A00240);
        // The refilled line is clean, so the return to tag 0 needs no write-back
        access(1, 0, 32'h40, 0, 1, 2, mk_line(32'h11110040, 32'h0), st, rv);
        check("t3_back_stalls", st, 4);
        check("t3_back_nreq", n_req, 1);
        check("t3_back_wr", log_wr[0], 0);
        check("t3_back_rdata", rv, 32'h11110040);

        // Test 4: a store miss on a clean line, then a load, then eviction of the dirty line
        access(0, 1, 32'h80, 32'h0BADF00D, 1, 2, mk_line(32'h55550080, 32'h0), st, rv);
        check("t4_st_stalls", st, 4);
        check("t4_st_addr", log_addr[0], 32'h80);
        access(1, 0, 32'h80, 0, 1, 1, '0, st, rv);
        check("t4_ld_stalls", st, 0);
        check("t4_ld_rdata", rv, 32'h0BADF00D);
        access(1, 0, 32'h280, 0, 1, 1, mk_line(32'h77770280, 32'h0), st, rv);
        check("t4_ev_stalls", st, 5);
        check("t4_ev_wb_addr", log_addr[0], 32'h80);
        check("t4_ev_wb_data", log_wdata[0][31:0], 32'h0BADF00D);
        check("t4_ev_rdata", rv, 32'h77770280);

        // Test 5: a reset during a refill
        cpu_read = 1'b1; cpu_addr = 32'h300; mem_rdata = mk_line(32'hEEEE0300, 32'h0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (mem_enable) begin seen = 1; break; end
        end
        check("t5_refill_seen", seen, 1);
        check("t5_refill_addr", mem_addr, 32'h300);
        rst = 1'b1;
        #1;
        check("t5_rst_en", mem_enable, 0);
        check("t5_rst_stall", cpu_stall, 1);
        @(negedge clk);
        rst = 1'b0;
        cpu_read = 1'b0;
        @(negedge clk);
        access(1, 0, 32'h300, 0, 1, 1, mk_line(32'h33330300, 32'h0), st, rv);
        check("t5_reload_stalls", st, 3);
        check("t5_reload_nreq", n_req, 1);
        check("t5_reload_rdata", rv, 32'h33330300);

        // Test 6: a spurious ack with no request pending
        mem_rdata = '1;
        mem_ack = 1'b1;
        #1;
        check("t6_stall", cpu_stall, 0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check("t6_mem_en", mem_enable, 0);
        @(negedge clk);
        access(1, 0, 32'h300, 0, 1, 1, '0, st, rv);
        check("t6_hit_stalls", st, 0);
        check("t6_hit_rdata", rv, 32'h33330300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
